// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus 32-bit datapath with externally strobed register loads, bus drives and a 64-bit-result ALU.
module cpu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic [4:0]       opcode,
  input  logic             Read,
  input  logic             IncPC,
  input  logic             R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic             R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             Yin,
  input  logic             Zhighin,
  input  logic             Zlowin,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             MARin,
  input  logic             Inportin,
  input  logic             MDRin,
  input  logic             Cin,
  input  logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             Yout,
  input  logic             Zhighout,
  input  logic             Zlowout,
  input  logic             PCout,
  input  logic             IRout,
  input  logic             MARout,
  input  logic             MDRout,
  input  logic             Inportout,
  input  logic             Cout,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] BusMuxOut
);
  logic [WIDTH-1:0]   r_q [16];
  logic [WIDTH-1:0]   hi_q, lo_q, y_q, pc_q, ir_q, mar_q, mdr_q, inport_q, c_q;
  logic [2*WIDTH-1:0] z_q;
  logic [15:0]        r_in, r_out;
  logic [WIDTH-1:0]   bus, alu_lo, alu_hi;
  logic [4:0]         sh;
  logic [2*WIDTH-1:0] ror_w, rol_w;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   quot, rem;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  // Later assignments win, so sources are listed from lowest to highest priority.
  always_comb begin
    bus = '0;
    if (Cout) bus = c_q;
    if (Inportout) bus = inport_q;
    if (MDRout) bus = mdr_q;
    if (MARout) bus = mar_q;
    if (IRout) bus = ir_q;
    if (PCout) bus = pc_q;
    if (Zlowout) bus = z_q[WIDTH-1:0];
    if (Zhighout) bus = z_q[2*WIDTH-1:WIDTH];
    if (Yout) bus = y_q;
    if (LOout) bus = lo_q;
    if (HIout) bus = hi_q;
    for (int i = 15; i >= 0; i--) if (r_out[i]) bus = r_q[i];
  end

  assign BusMuxOut = bus;

  assign sh    = bus[4:0];
  assign ror_w = {y_q, y_q} >> sh;
  assign rol_w = {y_q, y_q} << sh;
  assign prod  = $signed({{WIDTH{y_q[WIDTH-1]}}, y_q}) * $signed({{WIDTH{bus[WIDTH-1]}}, bus});
  assign quot  = $signed(y_q) / $signed(bus);
  assign rem   = $signed(y_q) % $signed(bus);

  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    if (IncPC) alu_lo = bus + WIDTH'(1);
    else case (opcode)
      5'd0:  alu_lo = y_q & bus;
      5'd1:  alu_lo = y_q | bus;
      5'd2:  alu_lo = y_q + bus;
      5'd3:  alu_lo = y_q - bus;
      5'd4:  alu_lo = y_q >> sh;
      5'd5:  alu_lo = y_q << sh;
      5'd6:  alu_lo = ror_w[WIDTH-1:0];
      5'd7:  alu_lo = rol_w[2*WIDTH-1:WIDTH];
      5'd8:  alu_lo = -bus;
      5'd9:  alu_lo = ~bus;
      5'd10: {alu_hi, alu_lo} = prod;
      5'd11: if (bus != '0) {alu_hi, alu_lo} = {rem, quot};
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      y_q      <= '0;
      z_q      <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      inport_q <= '0;
      c_q      <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (r_in[i]) r_q[i] <= bus;
      if (HIin) hi_q <= bus;
      if (LOin) lo_q <= bus;
      if (Yin) y_q <= bus;
      if (Zlowin) z_q[WIDTH-1:0] <= alu_lo;
      if (Zhighin) z_q[2*WIDTH-1:WIDTH] <= alu_hi;
      if (PCin) pc_q <= bus;
      if (IRin) ir_q <= bus;
      if (MARin) mar_q <= bus;
      if (Inportin) inport_q <= bus;
      if (MDRin) mdr_q <= Read ? Mdatain : bus;
      if (Cin) c_q <= {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};
    end
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed vector bench for the single-bus datapath.
module tb_cpu_datapath;
  logic        Clock, clear, Read, IncPC;
  logic [4:0]  opcode;
  logic [15:0] rin, rout;
  logic        HIin, LOin, Yin, Zhighin, Zlowin, PCin, IRin, MARin, Inportin, MDRin, Cin;
  logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout, Inportout, Cout;
  logic [31:0] Mdatain, BusMuxOut;
  int          n_cmp, n_fail;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        inc;
    logic [31:0] a, b, lo, hi;
  } vec_t;

  cpu_datapath dut (
    .Clock(Clock), .clear(clear), .opcode(opcode), .Read(Read), .IncPC(IncPC),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zhighin(Zhighin), .Zlowin(Zlowin),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .Inportin(Inportin), .MDRin(MDRin), .Cin(Cin),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Yout(Yout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .IRout(IRout), .MARout(MARout), .MDRout(MDRout),
    .Inportout(Inportout), .Cout(Cout),
    .Mdatain(Mdatain), .BusMuxOut(BusMuxOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic zero();
    rin = '0; rout = '0; Read = 0; IncPC = 0;
    {HIin, LOin, Yin, Zhighin, Zlowin, PCin, IRin, MARin, Inportin, MDRin, Cin} = '0;
    {HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout, Inportout, Cout} = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] exp);
    #1;
    n_cmp++;
    if (BusMuxOut !== exp) begin
      n_fail++;
      $display("FAIL %s: bus=%h expected=%h", name, BusMuxOut, exp);
    end
  endtask

  task automatic mdr_load(input logic [31:0] v);
    zero();
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
    zero();
  endtask

  task automatic put_bus(input logic [31:0] v);
    mdr_load(v);
    MDRout = 1;
  endtask

  function automatic logic [31:0] rv(input int i);
    return 32'hA500_0000 | (32'(i) * 32'h0001_0101);
  endfunction

  vec_t vt[$];

  initial begin
    n_cmp = 0; n_fail = 0;
    vt.push_back('{"and",    5'd0,  1'b0, 32'h34,       32'h45,       32'h4,        32'h0});
    vt.push_back('{"or",     5'd1,  1'b0, 32'h34,       32'h45,       32'h75,       32'h0});
    vt.push_back('{"add",    5'd2,  1'b0, 32'h34,       32'h45,       32'h79,       32'h0});
    vt.push_back('{"addwrap",5'd2,  1'b0, 32'hFFFFFFFF, 32'h2,        32'h1,        32'h0});
    vt.push_back('{"mulneg", 5'd10, 1'b0, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 32'hFFFFFFFF});
    vt.push_back('{"sub",    5'd3,  1'b0, 32'h34,       32'h45,       32'hFFFFFFEF, 32'h0});
    vt.push_back('{"shr",    5'd4,  1'b0, 32'h80000000, 32'h4,        32'h08000000, 32'h0});
    vt.push_back('{"shr0",   5'd4,  1'b0, 32'h12345678, 32'h20,       32'h12345678, 32'h0});
    vt.push_back('{"shl",    5'd5,  1'b0, 32'h0000000F, 32'd28,       32'hF0000000, 32'h0});
    vt.push_back('{"ror",    5'd6,  1'b0, 32'h00000001, 32'h1,        32'h80000000, 32'h0});
    vt.push_back('{"ror0",   5'd6,  1'b0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0});
    vt.push_back('{"rol",    5'd7,  1'b0, 32'h80000001, 32'h4,        32'h00000018, 32'h0});
    vt.push_back('{"neg",    5'd8,  1'b0, 32'h34,       32'h5,        32'hFFFFFFFB, 32'h0});
    vt.push_back('{"not",    5'd9,  1'b0, 32'h34,       32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0});
    vt.push_back('{"mul",    5'd10, 1'b0, 32'h34,       32'h45,       32'h00000E04, 32'h0});
    vt.push_back('{"div",    5'd11, 1'b0, 32'h45,       32'h34,       32'h1,        32'h11});
    vt.push_back('{"divneg", 5'd11, 1'b0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF});
    vt.push_back('{"div0",   5'd11, 1'b0, 32'h45,       32'h0,        32'h0,        32'h0});
    vt.push_back('{"mul2",   5'd10, 1'b0, 32'h10000,    32'h10000,    32'h0,        32'h1});
    vt.push_back('{"badop",  5'd12, 1'b0, 32'h34,       32'h45,       32'h0,        32'h0});
    vt.push_back('{"incpc",  5'd2,  1'b1, 32'h34,       32'h5,        32'h6,        32'h0});

    zero(); opcode = 0; Mdatain = 32'hFFFF_FFFF; clear = 0;
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      rout[i] = 1; chk($sformatf("rst_r%0d", i), 32'h0); rout[i] = 0;
    end
    Zlowout = 1; chk("rst_zlo", 32'h0); Zlowout = 0;
    MDRout = 1; chk("rst_mdr", 32'h0); MDRout = 0;
    clear = 1;
    tick();

    for (int i = 0; i < 16; i++) begin
      put_bus(rv(i)); rin[i] = 1; tick(); zero();
    end
    for (int i = 0; i < 16; i++) begin
      rout[i] = 1; chk($sformatf("reg_r%0d", i), rv(i)); rout[i] = 0;
    end
    put_bus(32'h1111_0001); HIin = 1; tick(); zero();
    put_bus(32'h2222_0002); LOin = 1; tick(); zero();
    put_bus(32'h3333_0003); MARin = 1; tick(); zero();
    put_bus(32'h4444_0004); Inportin = 1; tick(); zero();
    HIout = 1; chk("hi", 32'h1111_0001); HIout = 0;
    LOout = 1; chk("lo", 32'h2222_0002); LOout = 0;
    MARout = 1; chk("mar", 32'h3333_0003); MARout = 0;
    Inportout = 1; chk("inport", 32'h4444_0004); Inportout = 0;
    HIout = 1; LOout = 1; Cout = 1; chk("prio_hi_lo", 32'h1111_0001); zero();

    put_bus(32'h34); rin[2] = 1; tick(); zero();
    put_bus(32'h45); rin[4] = 1; tick(); zero();
    rout[2] = 1; Yin = 1; tick(); zero();
    Yout = 1; chk("y", 32'h34); Yout = 0;
    rout[4] = 1; opcode = 5'd0; Zlowin = 1; tick(); zero();
    Zlowout = 1; rin[5] = 1; chk("zlow_and_bus", 32'h4); tick(); zero();
    rout[5] = 1; chk("r5_and", 32'h4); rout[5] = 0;

    #2 clear = 0;
    rout[2] = 1; chk("async_r2", 32'h0); rout[2] = 0;
    Zlowout = 1; chk("async_zlo", 32'h0); Zlowout = 0;
    Mdatain = 32'h99; Read = 1; MDRin = 1; tick(); zero();
    MDRout = 1; chk("load_ignored", 32'h0); MDRout = 0;
    clear = 1;
    Mdatain = 32'h99; Read = 1; MDRin = 1; tick(); zero();
    MDRout = 1; chk("load_resumed", 32'h99); MDRout = 0;

    foreach (vt[k]) begin
      put_bus(vt[k].a); Yin = 1; tick(); zero();
      put_bus(vt[k].b); opcode = vt[k].op; IncPC = vt[k].inc; Zhighin = 1; Zlowin = 1; tick(); zero();
      Zlowout = 1; chk({vt[k].name, "_lo"}, vt[k].lo); Zlowout = 0;
      Zhighout = 1; chk({vt[k].name, "_hi"}, vt[k].hi); Zhighout = 0;
    end

    put_bus(32'h5); PCin = 1; tick(); zero();
    PCout = 1; IncPC = 1; opcode = 5'd3; Zlowin = 1; tick(); zero();
    Zlowout = 1; PCin = 1; tick(); zero();
    PCout = 1; chk("pc_inc", 32'h6); PCout = 0;

    put_bus(32'h0007_FFFF); IRin = 1; tick(); zero();
    IRout = 1; chk("ir", 32'h0007_FFFF); IRout = 0;
    Cin = 1; tick(); zero();
    Cout = 1; rin[1] = 1; tick(); zero();
    rout[1] = 1; chk("c_signext", 32'hFFFF_FFFF); rout[1] = 0;
    put_bus(32'hFFF1_2345); IRin = 1; tick(); zero();
    Cin = 1; tick(); zero();
    Cout = 1; chk("c_posext", 32'h0001_2345); Cout = 0;

    put_bus(32'h33); rin[3] = 1; tick(); zero();
    rout[1] = 1; rout[3] = 1; chk("prio_r1_r3", 32'hFFFF_FFFF); zero();
    rout[3] = 1; Read = 0; MDRin = 1; tick(); zero();
    MDRout = 1; chk("mdr_from_bus", 32'h33); MDRout = 0;
    Mdatain = 32'hDEAD_BEEF; chk("no_strobe", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
